// File: rtl/jamma_input_scanner.sv
// jamma_input_scanner
//
// Scans a time-multiplexed JAMMA-style button bus. Each player owns one
// slot. A slot is SETTLE idle cycles followed by one SAMPLE cycle. Every
// sampled word is debounced per player before it reaches joy_n. Raw coin
// switches are synchronised, and each falling edge is stretched into a
// fixed-length low pulse.
//
// Parameters
//   NPLAYERS    players on the shared bus (1..4)
//   WIDTH       bits per player word
//   SETTLE      idle cycles after a select change before sampling (0..15)
//   DEBOUNCE    consecutive identical samples needed to commit (1..15)
//   COIN_PULSE  coin output pulse length in cycles (1..255)
//   MERGE_LOCAL 1: the local joystick is ANDed into player 0
//
// Ports
//   pclk        clock, rising edge
//   reset_n     asynchronous active-low reset
//   bus_n       shared active-low button bus from the external mux
//   local_n     active-low local joystick
//   coin_n      active-low raw coin switches, one per player
//   sel         external mux select (current slot index)
//   joy_n       debounced active-low words, player p at [p*WIDTH +: WIDTH]
//   coin_out_n  stretched active-low coin pulses
//   scan_done   one-cycle pulse after the last player of a scan is sampled
//
// Slot FSM states
//   state      | meaning
//   ST_SETTLE  | mux select just changed, waiting for the bus to settle
//   ST_SAMPLE  | bus is valid for slot sel, sample and debounce this cycle
module jamma_input_scanner #(
    parameter int NPLAYERS    = 2,
    parameter int WIDTH       = 8,
    parameter int SETTLE      = 0,
    parameter int DEBOUNCE    = 3,
    parameter int COIN_PULSE  = 16,
    parameter int MERGE_LOCAL = 1,
    localparam int SEL_W      = (NPLAYERS > 1) ? $clog2(NPLAYERS) : 1
) (
    input  logic                      pclk,
    input  logic                      reset_n,
    input  logic [WIDTH-1:0]          bus_n,
    input  logic [WIDTH-1:0]          local_n,
    input  logic [NPLAYERS-1:0]       coin_n,
    output logic [SEL_W-1:0]          sel,
    output logic [NPLAYERS*WIDTH-1:0] joy_n,
    output logic [NPLAYERS-1:0]       coin_out_n,
    output logic                      scan_done
);

    typedef enum logic {
        ST_SETTLE = 1'b0,
        ST_SAMPLE = 1'b1
    } state_t;

    // With SETTLE=0 the settle state is never entered, so every slot is a
    // single SAMPLE cycle.
    localparam state_t          ST_FIRST    = (SETTLE > 0) ? ST_SETTLE : ST_SAMPLE;
    localparam logic [3:0]      SETTLE_LOAD = (SETTLE > 0) ? 4'(SETTLE - 1) : 4'd0;
    localparam logic [3:0]      DB_MAX      = 4'(DEBOUNCE - 1);
    localparam logic [SEL_W-1:0] LAST_SLOT  = SEL_W'(NPLAYERS - 1);
    localparam logic [7:0]      PULSE_LOAD  = 8'(COIN_PULSE - 1);

    // ------------------------------------------------------------------
    // Slot sequencing
    // ------------------------------------------------------------------
    state_t           state_q, state_d;
    logic [3:0]       settle_cnt_q, settle_cnt_d;
    logic [SEL_W-1:0] slot_q, slot_d;
    logic             sample_en;

    always_ff @(posedge pclk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_FIRST;
            settle_cnt_q <= SETTLE_LOAD;
            slot_q       <= '0;
        end else begin
            state_q      <= state_d;
            settle_cnt_q <= settle_cnt_d;
            slot_q       <= slot_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        settle_cnt_d = settle_cnt_q;
        slot_d       = slot_q;
        sample_en    = 1'b0;
        case (state_q)
            ST_SETTLE: begin
                if (settle_cnt_q == 4'd0) begin
                    state_d = ST_SAMPLE;
                end else begin
                    settle_cnt_d = settle_cnt_q - 4'd1;
                end
            end
            ST_SAMPLE: begin
                sample_en    = 1'b1;
                state_d      = ST_FIRST;
                settle_cnt_d = SETTLE_LOAD;
                slot_d       = (slot_q == LAST_SLOT) ? '0 : slot_q + SEL_W'(1);
            end
        endcase
    end

    assign sel = slot_q;

    // ------------------------------------------------------------------
    // Sampling and per-player debounce
    // ------------------------------------------------------------------
    logic [WIDTH-1:0]          sample_w;
    logic [WIDTH-1:0]          last_q [NPLAYERS];
    logic [WIDTH-1:0]          last_d [NPLAYERS];
    logic [3:0]                cnt_q  [NPLAYERS];
    logic [3:0]                cnt_d  [NPLAYERS];
    logic [NPLAYERS*WIDTH-1:0] joy_q, joy_d;
    logic                      scan_done_q, scan_done_d;

    always_comb begin
        sample_w = bus_n;
        if (MERGE_LOCAL != 0 && slot_q == '0) begin
            sample_w = bus_n & local_n;
        end
    end

    // Only the player owning the current SAMPLE slot can change, so a
    // word is never committed outside its own slot.
    always_comb begin
        joy_d       = joy_q;
        scan_done_d = sample_en && (slot_q == LAST_SLOT);
        for (int p = 0; p < NPLAYERS; p++) begin
            last_d[p] = last_q[p];
            cnt_d[p]  = cnt_q[p];
            if (sample_en && slot_q == SEL_W'(p)) begin
                if (sample_w == last_q[p]) begin
                    cnt_d[p] = (cnt_q[p] >= DB_MAX) ? DB_MAX : cnt_q[p] + 4'd1;
                end else begin
                    last_d[p] = sample_w;
                    cnt_d[p]  = 4'd0;
                end
                // Once the run is long enough, every further matching
                // sample re-commits the same value, which is harmless.
                if (cnt_d[p] == DB_MAX) begin
                    joy_d[p*WIDTH +: WIDTH] = last_d[p];
                end
            end
        end
    end

    always_ff @(posedge pclk or negedge reset_n) begin
        if (!reset_n) begin
            joy_q       <= '1;
            scan_done_q <= 1'b0;
            for (int p = 0; p < NPLAYERS; p++) begin
                last_q[p] <= '1;
                cnt_q[p]  <= 4'd0;
            end
        end else begin
            joy_q       <= joy_d;
            scan_done_q <= scan_done_d;
            for (int p = 0; p < NPLAYERS; p++) begin
                last_q[p] <= last_d[p];
                cnt_q[p]  <= cnt_d[p];
            end
        end
    end

    assign joy_n     = joy_q;
    assign scan_done = scan_done_q;

    // ------------------------------------------------------------------
    // Coin synchronisers and pulse stretchers
    // ------------------------------------------------------------------
    logic [NPLAYERS-1:0] sync1_q, sync1_d;
    logic [NPLAYERS-1:0] sync2_q, sync2_d;
    logic [NPLAYERS-1:0] prev_q, prev_d;
    logic [NPLAYERS-1:0] coin_out_q, coin_out_d;
    logic [7:0]          pulse_cnt_q [NPLAYERS];
    logic [7:0]          pulse_cnt_d [NPLAYERS];
    logic [NPLAYERS-1:0] fall_w;

    // prev_q is the synchronised level one cycle earlier; it keeps
    // tracking during a pulse, so a coin held low cannot re-trigger.
    assign fall_w = prev_q & ~sync2_q;

    always_comb begin
        sync1_d    = coin_n;
        sync2_d    = sync1_q;
        prev_d     = sync2_q;
        coin_out_d = coin_out_q;
        for (int i = 0; i < NPLAYERS; i++) begin
            pulse_cnt_d[i] = pulse_cnt_q[i];
            if (!coin_out_q[i]) begin
                if (pulse_cnt_q[i] == 8'd0) begin
                    coin_out_d[i] = 1'b1;
                end else begin
                    pulse_cnt_d[i] = pulse_cnt_q[i] - 8'd1;
                end
            end else if (fall_w[i]) begin
                coin_out_d[i]  = 1'b0;
                pulse_cnt_d[i] = PULSE_LOAD;
            end
        end
    end

    always_ff @(posedge pclk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q    <= '1;
            sync2_q    <= '1;
            prev_q     <= '1;
            coin_out_q <= '1;
            for (int i = 0; i < NPLAYERS; i++) begin
                pulse_cnt_q[i] <= 8'd0;
            end
        end else begin
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            prev_q     <= prev_d;
            coin_out_q <= coin_out_d;
            for (int i = 0; i < NPLAYERS; i++) begin
                pulse_cnt_q[i] <= pulse_cnt_d[i];
            end
        end
    end

    assign coin_out_n = coin_out_q;

endmodule

// File: tb/tb_jamma_input_scanner.sv
// Testbench for jamma_input_scanner: two instances (defaults, and a
// three-player configuration with settle time), directed scenarios, and a
// randomized run checked against a behavioural model.
module tb_jamma_input_scanner;

    logic        clk;
    logic        rst_a, rst_b;
    logic [7:0]  bus_a, loc_a, bus_b, loc_b;
    logic [1:0]  coin_a;
    logic [2:0]  coin_b;
    logic [0:0]  sel_a;
    logic [1:0]  sel_b;
    logic [15:0] joy_a;
    logic [23:0] joy_b;
    logic [1:0]  cout_a;
    logic [2:0]  cout_b;
    logic        done_a, done_b;

    int total = 0;
    int bad   = 0;

    jamma_input_scanner u_a (
        .pclk(clk), .reset_n(rst_a), .bus_n(bus_a), .local_n(loc_a),
        .coin_n(coin_a), .sel(sel_a), .joy_n(joy_a), .coin_out_n(cout_a),
        .scan_done(done_a)
    );

    jamma_input_scanner #(
        .NPLAYERS(3), .WIDTH(8), .SETTLE(2), .DEBOUNCE(2),
        .COIN_PULSE(5), .MERGE_LOCAL(0)
    ) u_b (
        .pclk(clk), .reset_n(rst_b), .bus_n(bus_b), .local_n(loc_b),
        .coin_n(coin_b), .sel(sel_b), .joy_n(joy_b), .coin_out_n(cout_b),
        .scan_done(done_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    function automatic int np(input int i); return (i == 0) ? 2 : 3;  endfunction
    function automatic int st(input int i); return (i == 0) ? 0 : 2;  endfunction
    function automatic int db(input int i); return (i == 0) ? 3 : 2;  endfunction
    function automatic int cp(input int i); return (i == 0) ? 16 : 5; endfunction
    function automatic int ml(input int i); return (i == 0) ? 1 : 0;  endfunction

    int         mk    [2];          // clock edges since reset release
    logic [7:0] mhist [2][3][16];   // newest sample at index 0
    int         mlen  [2][3];
    logic [7:0] mjoy  [2][3];
    int         msel  [2];
    logic       mdone [2];
    logic       mraw  [2][3][3];    // raw coin samples, newest at index 0
    int         mleft [2][3];
    logic       mcout [2][3];

    task automatic model_reset(input int i);
        mk[i]    = 0;
        msel[i]  = 0;
        mdone[i] = 1'b0;
        for (int p = 0; p < 3; p++) begin
            mhist[i][p][0] = 8'hFF;   // reset last-sample acts as one FF sample
            mlen[i][p]     = 1;
            mjoy[i][p]     = 8'hFF;
            mleft[i][p]    = 0;
            mcout[i][p]    = 1'b1;
            for (int j = 0; j < 3; j++) mraw[i][p][j] = 1'b1;
        end
    endtask

    task automatic model_edge(input int i, input logic [7:0] bus,
                              input logic [7:0] loc, input logic [2:0] coin);
        int         per;
        int         slot;
        logic [7:0] s;
        bit         same;
        bit         fall;
        per      = st(i) + 1;
        slot     = (mk[i] / per) % np(i);
        mdone[i] = 1'b0;
        if (mk[i] % per == st(i)) begin
            s = bus & ((slot == 0 && ml(i) == 1) ? loc : 8'hFF);
            for (int j = 15; j > 0; j--) mhist[i][slot][j] = mhist[i][slot][j-1];
            mhist[i][slot][0] = s;
            if (mlen[i][slot] < 16) mlen[i][slot]++;
            if (mlen[i][slot] >= db(i)) begin
                same = 1'b1;
                for (int j = 0; j < db(i); j++)
                    if (mhist[i][slot][j] != s) same = 1'b0;
                if (same) mjoy[i][slot] = s;
            end
            mdone[i] = (slot == np(i) - 1);
        end
        mk[i]++;
        msel[i] = (mk[i] / per) % np(i);
        for (int c = 0; c < np(i); c++) begin
            // Falling edge of the synchronised level: sample two back low,
            // sample three back high.
            fall = !mraw[i][c][1] && mraw[i][c][2];
            if (mleft[i][c] > 0) mleft[i][c]--;
            else if (fall)       mleft[i][c] = cp(i);
            mcout[i][c] = (mleft[i][c] > 0) ? 1'b0 : 1'b1;
            mraw[i][c][2] = mraw[i][c][1];
            mraw[i][c][1] = mraw[i][c][0];
            mraw[i][c][0] = coin[c];
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst_a) model_edge(0, bus_a, loc_a, {1'b1, coin_a});
        if (rst_b) model_edge(1, bus_b, loc_b, coin_b);
        #1;
    endtask

    task automatic idle_inputs();
        bus_a = 8'hFF; loc_a = 8'hFF; coin_a = 2'b11;
        bus_b = 8'hFF; loc_b = 8'hFF; coin_b = 3'b111;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_a = 1'b0; rst_b = 1'b0;
        model_reset(0); model_reset(1);
        tick(); tick();
        rst_a = 1'b1; rst_b = 1'b1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        idle_inputs();
        rst_a = 1'b0; rst_b = 1'b0;
        model_reset(0); model_reset(1);
        #1;
        tick(); tick();
        total++; if (sel_a !== 1'b0) begin bad++; $display("FAIL reset_sel_a got=%0h want=0", sel_a); end
        total++; if (sel_b !== 2'b00) begin bad++; $display("FAIL reset_sel_b got=%0h want=0", sel_b); end
        total++; if (joy_a !== 16'hFFFF) begin bad++; $display("FAIL reset_joy_a got=%0h want=ffff", joy_a); end
        total++; if (joy_b !== 24'hFFFFFF) begin bad++; $display("FAIL reset_joy_b got=%0h want=ffffff", joy_b); end
        total++; if (cout_a !== 2'b11) begin bad++; $display("FAIL reset_coin_a got=%0b want=11", cout_a); end
        total++; if (cout_b !== 3'b111) begin bad++; $display("FAIL reset_coin_b got=%0b want=111", cout_b); end
        total++; if (done_a !== 1'b0) begin bad++; $display("FAIL reset_done_a got=%0b want=0", done_a); end
        total++; if (done_b !== 1'b0) begin bad++; $display("FAIL reset_done_b got=%0b want=0", done_b); end
        rst_a = 1'b1; rst_b = 1'b1;
    endtask

    task automatic test_scan_sequence();
        int pulses;
        do_reset();
        pulses = 0;
        for (int j = 0; j <= 18; j++) begin
            total++;
            if (sel_b !== 2'((j / 3) % 3)) begin
                bad++; $display("FAIL seq_sel_b j=%0d got=%0d want=%0d", j, sel_b, (j / 3) % 3);
            end
            total++;
            if (done_b !== (j > 0 && j % 9 == 0)) begin
                bad++; $display("FAIL seq_done_b j=%0d got=%0b want=%0b", j, done_b, (j > 0 && j % 9 == 0));
            end
            total++;
            if (sel_a !== 1'(j % 2)) begin
                bad++; $display("FAIL seq_sel_a j=%0d got=%0d want=%0d", j, sel_a, j % 2);
            end
            total++;
            if (done_a !== (j > 0 && j % 2 == 0)) begin
                bad++; $display("FAIL seq_done_a j=%0d got=%0b want=%0b", j, done_a, (j > 0 && j % 2 == 0));
            end
            if (done_b === 1'b1) pulses++;
            tick();
        end
        total++;
        if (pulses != 2) begin bad++; $display("FAIL seq_done_count got=%0d want=2", pulses); end
    endtask

    task automatic test_debounce_commit();
        do_reset();
        for (int j = 0; j <= 8; j++) begin
            bus_a = (sel_a == 1'b0) ? 8'hFE : 8'hFF;
            total++;
            if (joy_a[7:0] !== ((j >= 5) ? 8'hFE : 8'hFF)) begin
                bad++; $display("FAIL db_joy0 j=%0d got=%0h want=%0h", j, joy_a[7:0], (j >= 5) ? 8'hFE : 8'hFF);
            end
            total++;
            if (joy_a[15:8] !== 8'hFF) begin
                bad++; $display("FAIL db_joy1 j=%0d got=%0h want=ff", j, joy_a[15:8]);
            end
            tick();
        end
    endtask

    task automatic test_bounce();
        int n0;
        do_reset();
        n0 = 0;
        for (int j = 0; j < 40; j++) begin
            if (sel_a == 1'b0) begin
                bus_a = (n0 % 2 == 0) ? 8'hFE : 8'hFF;
                n0++;
            end else begin
                bus_a = 8'hFF;
            end
            total++;
            if (joy_a[7:0] !== 8'hFF) begin
                bad++; $display("FAIL bounce_joy0 j=%0d got=%0h want=ff", j, joy_a[7:0]);
            end
            tick();
        end
    endtask

    task automatic test_merge();
        do_reset();
        bus_a = 8'hFF;
        loc_a = 8'hFD;
        for (int j = 0; j <= 8; j++) begin
            total++;
            if (joy_a[7:0] !== ((j >= 5) ? 8'hFD : 8'hFF)) begin
                bad++; $display("FAIL merge_joy0 j=%0d got=%0h want=%0h", j, joy_a[7:0], (j >= 5) ? 8'hFD : 8'hFF);
            end
            total++;
            if (joy_a[15:8] !== 8'hFF) begin
                bad++; $display("FAIL merge_joy1 j=%0d got=%0h want=ff", j, joy_a[15:8]);
            end
            tick();
        end
        loc_a = 8'hFF;
    endtask

    task automatic test_coin();
        int first [2];
        int lows  [2];
        int starts[2];
        logic was_low [2];
        do_reset();
        for (int c = 0; c < 2; c++) begin
            first[c] = -1; lows[c] = 0; starts[c] = 0; was_low[c] = 1'b0;
        end
        coin_a = 2'b00;
        for (int j = 1; j <= 130; j++) begin
            tick();
            if (j == 100) coin_a = 2'b11;
            for (int c = 0; c < 2; c++) begin
                if (cout_a[c] === 1'b0) begin
                    lows[c]++;
                    if (first[c] < 0) first[c] = j;
                    if (!was_low[c]) starts[c]++;
                    was_low[c] = 1'b1;
                end else begin
                    was_low[c] = 1'b0;
                end
            end
        end
        for (int c = 0; c < 2; c++) begin
            total++;
            if (first[c] != 3) begin bad++; $display("FAIL coin_start bit=%0d got=%0d want=3", c, first[c]); end
            total++;
            if (lows[c] != 16) begin bad++; $display("FAIL coin_len bit=%0d got=%0d want=16", c, lows[c]); end
            total++;
            if (starts[c] != 1) begin bad++; $display("FAIL coin_pulses bit=%0d got=%0d want=1", c, starts[c]); end
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        coin_a = 2'b00;
        for (int j = 0; j < 4; j++) begin
            bus_a = (sel_a == 1'b0) ? 8'hFE : 8'hFF;
            tick();
        end
        total++;
        if (cout_a !== 2'b00) begin bad++; $display("FAIL mid_pre_coin got=%0b want=00", cout_a); end
        #2;
        rst_a = 1'b0;
        model_reset(0);
        coin_a = 2'b11;
        bus_a  = 8'hFF;
        #1;
        total++; if (sel_a !== 1'b0) begin bad++; $display("FAIL mid_sel got=%0h want=0", sel_a); end
        total++; if (joy_a !== 16'hFFFF) begin bad++; $display("FAIL mid_joy got=%0h want=ffff", joy_a); end
        total++; if (cout_a !== 2'b11) begin bad++; $display("FAIL mid_coin got=%0b want=11", cout_a); end
        total++; if (done_a !== 1'b0) begin bad++; $display("FAIL mid_done got=%0b want=0", done_a); end
        tick();
        tick();
        rst_a = 1'b1;
        for (int j = 0; j < 30; j++) begin
            total++;
            if (joy_a !== 16'hFFFF || cout_a !== 2'b11) begin
                bad++; $display("FAIL mid_after j=%0d joy=%0h coin=%0b want joy=ffff coin=11", j, joy_a, cout_a);
            end
            tick();
        end
    endtask

    task automatic test_random();
        logic [7:0] wa [2];
        logic [7:0] wb [3];
        int         ra, rb;
        do_reset();
        wa[0] = 8'hFF; wa[1] = 8'hFF;
        wb[0] = 8'hFF; wb[1] = 8'hFF; wb[2] = 8'hFF;
        ra = 0; rb = 0;
        for (int n = 0; n < 3000; n++) begin
            if (ra > 0) begin
                ra--; if (ra == 0) rst_a = 1'b1;
            end else if ($urandom_range(0, 399) == 0) begin
                rst_a = 1'b0; model_reset(0); ra = 2;
            end
            if (rb > 0) begin
                rb--; if (rb == 0) rst_b = 1'b1;
            end else if ($urandom_range(0, 399) == 0) begin
                rst_b = 1'b0; model_reset(1); rb = 2;
            end
            if ($urandom_range(0, 15) == 0) wa[$urandom_range(0, 1)] = 8'($urandom);
            if ($urandom_range(0, 15) == 0) wb[$urandom_range(0, 2)] = 8'($urandom);
            if ($urandom_range(0, 31) == 0) loc_a = ($urandom_range(0, 1) == 0) ? 8'hFF : 8'($urandom);
            loc_b  = 8'($urandom);
            bus_a  = ($urandom_range(0, 19) == 0) ? 8'($urandom) : wa[sel_a];
            bus_b  = ($urandom_range(0, 19) == 0) ? 8'($urandom) : wb[(sel_b > 2'd2) ? 2'd0 : sel_b];
            for (int c = 0; c < 2; c++) if ($urandom_range(0, 29) == 0) coin_a[c] = ~coin_a[c];
            for (int c = 0; c < 3; c++) if ($urandom_range(0, 29) == 0) coin_b[c] = ~coin_b[c];
            tick();
            total++;
            if (sel_a !== 1'(msel[0]) || sel_b !== 2'(msel[1])) begin
                bad++; $display("FAIL rnd_sel n=%0d got=%0d/%0d want=%0d/%0d", n, sel_a, sel_b, msel[0], msel[1]);
            end
            total++;
            if (done_a !== mdone[0] || done_b !== mdone[1]) begin
                bad++; $display("FAIL rnd_done n=%0d got=%0b/%0b want=%0b/%0b", n, done_a, done_b, mdone[0], mdone[1]);
            end
            for (int p = 0; p < 2; p++) begin
                total++;
                if (joy_a[p*8 +: 8] !== mjoy[0][p] || cout_a[p] !== mcout[0][p]) begin
                    bad++; $display("FAIL rnd_a n=%0d p=%0d got joy=%0h coin=%0b want joy=%0h coin=%0b",
                                    n, p, joy_a[p*8 +: 8], cout_a[p], mjoy[0][p], mcout[0][p]);
                end
            end
            for (int p = 0; p < 3; p++) begin
                total++;
                if (joy_b[p*8 +: 8] !== mjoy[1][p] || cout_b[p] !== mcout[1][p]) begin
                    bad++; $display("FAIL rnd_b n=%0d p=%0d got joy=%0h coin=%0b want joy=%0h coin=%0b",
                                    n, p, joy_b[p*8 +: 8], cout_b[p], mjoy[1][p], mcout[1][p]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_scan_sequence();
        test_debounce_commit();
        test_bounce();
        test_merge();
        test_coin();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/jamma_input_scanner.md
JAMMA_INPUT_SCANNER -- requirements
Module: jamma_input_scanner

Interface
REQ-001 SHALL have parameter NPLAYERS, default 2, number of players time-multiplexed on the shared bus (legal 1..4).
REQ-002 SHALL have parameter WIDTH, default 8, bits per player word on the shared bus.
REQ-003 SHALL have parameter SETTLE, default 0, idle cycles after each select change before sampling (legal 0..15).
REQ-004 SHALL have parameter DEBOUNCE, default 3, consecutive identical samples needed to commit a word (legal 1..15).
REQ-005 SHALL have parameter COIN_PULSE, default 16, coin output pulse length in cycles (legal 1..255).
REQ-006 SHALL have parameter MERGE_LOCAL, default 1; when 1 the local joystick is ANDed into player 0.
REQ-007 SHALL have port pclk, input, 1, the single clock; all logic is on its rising edge.
REQ-008 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-009 SHALL have port bus_n, input, WIDTH, shared active-low button bus from the external mux.
REQ-010 SHALL have port local_n, input, WIDTH, active-low local joystick, with unused upper bits tied high.
REQ-011 SHALL have port coin_n, input, NPLAYERS, active-low raw coin switches.
REQ-012 SHALL have port sel, output, max(1,clog2(NPLAYERS)), the external mux select.
REQ-013 SHALL have port joy_n, output, NPLAYERS*WIDTH, debounced active-low words; player p occupies bits [p*WIDTH +: WIDTH].
REQ-014 SHALL have port coin_out_n, output, NPLAYERS, stretched active-low coin pulses.
REQ-015 SHALL have port scan_done, output, 1, a one-cycle pulse after the last player of a scan is sampled.

Function
REQ-016 SHALL scan with a per-slot FSM: SETTLE_WAIT (SETTLE cycles, skipped when SETTLE=0), then SAMPLE (1 cycle), then advance; slot length is SETTLE+1 cycles.
REQ-017 SHALL hold sel at slot index p for the whole slot; sel advances p -> p+1 on the cycle after SAMPLE and wraps from NPLAYERS-1 to 0.
REQ-018 SHALL, with NPLAYERS=1, hold sel at 0 permanently and sample every SETTLE+1 cycles.
REQ-019 SHALL, in SAMPLE, register s = bus_n, or bus_n & local_n when p=0 and MERGE_LOCAL=1.
REQ-020 SHALL keep, per player, a last-sample register L and a saturating count C (4 bits).
REQ-021 SHALL, when s == L, set C = min(C+1, DEBOUNCE-1); when s != L, set L = s and C = 0.
REQ-022 SHALL update joy_n word p to L on the cycle after the sample at which C reaches DEBOUNCE-1; with DEBOUNCE=1 every sample is committed with 1-cycle latency.
REQ-023 SHALL never update joy_n for a player outside that player's SAMPLE slot.
REQ-024 SHALL assert scan_done for exactly the one cycle following SAMPLE of player NPLAYERS-1.
REQ-025 SHALL pass each coin_n bit through a 2-flop synchroniser before use.
REQ-026 SHALL, on a synchronised 1->0 edge of coin_n[i], drive coin_out_n[i] low for exactly COIN_PULSE cycles starting the next cycle.
REQ-027 SHALL ignore further edges on coin_n[i] while its pulse is active; a coin held low beyond the pulse produces no second pulse until it is released and pressed again.
REQ-028 SHALL process coin channels independently, so simultaneous coin edges each yield a full pulse.

Reset
REQ-029 SHALL, while reset_n=0, force sel=0, joy_n all 1, coin_out_n all 1, scan_done=0, all L all 1, all C=0, synchroniser flops 1, FSM at the start of slot 0.
REQ-030 SHALL, on reset assertion mid-slot or mid-pulse, abort immediately with no partial commit; after release, the first SAMPLE occurs SETTLE cycles later in slot 0.

Verification
REQ-031 SHALL cover: defaults, bus_n=8'hFE constant for player 0 and FF for player 1 -> joy_n[7:0]=FE committed on the 3rd player-0 sample; joy_n[15:8] stays FF.
REQ-032 SHALL cover: SETTLE=2, NPLAYERS=3 -> sel sequence 0,0,0,1,1,1,2,2,2,0 and scan_done high once per 9 cycles.
REQ-033 SHALL cover: bouncing bus alternating FE/FF every player-0 sample -> joy_n[7:0] remains FF indefinitely.
REQ-034 SHALL cover: MERGE_LOCAL=1, local_n=FD, bus_n=FF on slot 0 -> joy_n[7:0]=FD after debounce; player 1 unaffected.
REQ-035 SHALL cover: coin_n[0] low for 100 cycles with COIN_PULSE=16 -> a single 16-cycle low pulse starting 3 cycles after the edge; coin_n[1] pressed simultaneously -> an identical pulse on bit 1.
REQ-036 SHALL cover: reset_n pulsed low mid-pulse and mid-debounce -> all outputs at reset values within the same cycle, and no pulse or commit resumes after release.
